irq_ctrl: RTL and testbench

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_pkg.sv | 19 +
 rtl/irq_prio_enc.sv | 23 ++
 rtl/irq_ctrl.sv | 153 +++++++++++++++
 tb/tb_irq_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared constants and types for the interrupt controller.
// Register offsets, source count default, id width and FSM states.
package irq_pkg;

    localparam int unsigned NUM_SRC_DEF = 4;
    localparam int unsigned ID_W        = 2;

    localparam logic [31:0] OFF_IPEND  = 32'h0;
    localparam logic [31:0] OFF_IMASK  = 32'h4;
    localparam logic [31:0] OFF_ICAUSE = 32'h8;
    localparam logic [31:0] OFF_EOI    = 32'hC;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set bit wins.
// Purely combinational; idx is 0 when no bit is set.
module irq_prio_enc
    import irq_pkg::*;
#(
    parameter int unsigned N = NUM_SRC_DEF
) (
    input  logic [N-1:0]    cand,
    output logic            valid,
    output logic [ID_W-1:0] idx
);

    always_comb begin
        valid = |cand;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (cand[i]) begin
                idx = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: edge-latched pending bits,
// mask, lowest-index priority and a non-nesting request/service FSM.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int unsigned NUM_SRC   = NUM_SRC_DEF,
    parameter logic [31:0] BASE_ADDR = 32'h4000_0020
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        Address,
    input  logic [31:0]        Write_data,
    input  logic               MemWrite,
    input  logic               MemRead,
    output logic [31:0]        Read_data,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               cpu_ack,
    output logic               irq_out,
    output logic [ID_W-1:0]    irq_id
);

    logic [NUM_SRC-1:0] src_q, src_d;
    logic [NUM_SRC-1:0] ipend_q, ipend_d;
    logic [NUM_SRC-1:0] imask_q, imask_d;
    logic               armed_q, armed_d;
    irq_state_e         state_q, state_d;
    logic               irq_out_q, irq_out_d;
    logic [ID_W-1:0]    irq_id_q, irq_id_d;

    logic               sel_ipend, sel_imask, sel_icause, sel_eoi;
    logic               wr_ipend, wr_imask, wr_eoi;
    logic [NUM_SRC-1:0] cand;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] ack_clr;
    logic               win_valid;
    logic [ID_W-1:0]    win_idx;
    logic               ack_take;
    logic               unused_wdata;

    assign unused_wdata = ^Write_data;

    assign sel_ipend  = (Address == BASE_ADDR + OFF_IPEND);
    assign sel_imask  = (Address == BASE_ADDR + OFF_IMASK);
    assign sel_icause = (Address == BASE_ADDR + OFF_ICAUSE);
    assign sel_eoi    = (Address == BASE_ADDR + OFF_EOI);

    assign wr_ipend = MemWrite && sel_ipend;
    assign wr_imask = MemWrite && sel_imask;
    assign wr_eoi   = MemWrite && sel_eoi;

    assign cand = ipend_q & imask_q;

    irq_prio_enc #(
        .N (NUM_SRC)
    ) u_prio (
        .cand  (cand),
        .valid (win_valid),
        .idx   (win_idx)
    );

    // Edges are suppressed for the first cycle after reset so a line
    // held high across reset release is not mistaken for a new event.
    always_comb begin
        src_d   = irq_src;
        armed_d = 1'b1;
        rise    = armed_q ? (irq_src & ~src_q) : '0;
    end

    assign ack_take = (state_q == ST_REQ) && cpu_ack;
    assign ack_clr  = ack_take ? (NUM_SRC'(1) << irq_id_q) : '0;

    always_comb begin
        ipend_d = ipend_q;
        if (wr_ipend) begin
            ipend_d = ipend_d & ~Write_data[NUM_SRC-1:0];
        end
        ipend_d = (ipend_d & ~ack_clr) | rise;
    end

    always_comb begin
        imask_d = imask_q;
        if (wr_imask) begin
            imask_d = Write_data[NUM_SRC-1:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        irq_id_d = irq_id_q;
        unique case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    state_d  = ST_REQ;
                    irq_id_d = win_idx;
                end
            end
            ST_REQ: begin
                if (cpu_ack) begin
                    state_d = ST_SERVICE;
                end else if (!win_valid) begin
                    state_d = ST_IDLE;
                end else begin
                    irq_id_d = win_idx;
                end
            end
            ST_SERVICE: begin
                if (wr_eoi) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        irq_out_d = (state_d == ST_REQ);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_q     <= '0;
            ipend_q   <= '0;
            imask_q   <= '0;
            armed_q   <= 1'b0;
            state_q   <= ST_IDLE;
            irq_out_q <= 1'b0;
            irq_id_q  <= '0;
        end else begin
            src_q     <= src_d;
            ipend_q   <= ipend_d;
            imask_q   <= imask_d;
            armed_q   <= armed_d;
            state_q   <= state_d;
            irq_out_q <= irq_out_d;
            irq_id_q  <= irq_id_d;
        end
    end

    assign irq_out = irq_out_q;
    assign irq_id  = irq_id_q;

    always_comb begin
        Read_data = '0;
        if (MemRead) begin
            unique case (1'b1)
                sel_ipend:  Read_data = 32'(ipend_q);
                sel_imask:  Read_data = 32'(imask_q);
                sel_icause: Read_data = 32'(irq_id_q);
                default:    Read_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed scenarios plus random traffic for irq_ctrl,
// checked every cycle against a behavioural model.
module tb_irq_ctrl;

    localparam logic [31:0] BASE = 32'h4000_0020;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Address;
    logic [31:0] Write_data;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] Read_data;
    logic [3:0]  irq_src;
    logic        cpu_ack;
    logic        irq_out;
    logic [1:0]  irq_id;

    int n_chk = 0;
    int n_fail = 0;

    // model state
    logic [3:0] m_pend, m_mask, m_prev;
    bit         m_armed, m_req, m_svc;
    logic [1:0] m_id;

    irq_ctrl #(
        .NUM_SRC   (4),
        .BASE_ADDR (BASE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .Address    (Address),
        .Write_data (Write_data),
        .MemWrite   (MemWrite),
        .MemRead    (MemRead),
        .Read_data  (Read_data),
        .irq_src    (irq_src),
        .cpu_ack    (cpu_ack),
        .irq_out    (irq_out),
        .irq_id     (irq_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [31:0] exp_read();
        if (!MemRead) return 32'h0;
        if (Address == BASE) return {28'h0, m_pend};
        if (Address == BASE + 32'd4) return {28'h0, m_mask};
        if (Address == BASE + 32'd8) return {30'h0, m_id};
        return 32'h0;
    endfunction

    // One clock of the reference behaviour, from the inputs now applied.
    task automatic model_step();
        logic [3:0] rise, cand, clr;
        int w;
        rise = m_armed ? (irq_src & ~m_prev) : 4'b0;
        cand = m_pend & m_mask;
        w    = lowest(cand);
        clr  = 4'b0;
        if (MemWrite && Address == BASE) clr = Write_data[3:0];
        if (m_req && cpu_ack) clr[m_id] = 1'b1;
        if (m_req) begin
            if (cpu_ack) begin
                m_req = 0;
                m_svc = 1;
            end else if (w < 0) begin
                m_req = 0;
            end else begin
                m_id = 2'(w);
            end
        end else if (m_svc) begin
            if (MemWrite && Address == BASE + 32'd12) m_svc = 0;
        end else if (w >= 0) begin
            m_req = 1;
            m_id  = 2'(w);
        end
        m_pend = (m_pend & ~clr) | rise;
        if (MemWrite && Address == BASE + 32'd4) m_mask = Write_data[3:0];
        m_prev  = irq_src;
        m_armed = 1;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("irq_out", {31'h0, irq_out}, {31'h0, m_req});
        chk("irq_id", {30'h0, irq_id}, {30'h0, m_id});
        chk("read", Read_data, exp_read());
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        m_pend = 0; m_mask = 0; m_prev = 0;
        m_armed = 0; m_req = 0; m_svc = 0; m_id = 0;
        chk("rst_out", {31'h0, irq_out}, 32'h0);
        chk("rst_id", {30'h0, irq_id}, 32'h0);
        chk("rst_read", Read_data, exp_read());
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        Address    = a;
        Write_data = d;
        MemWrite   = 1'b1;
        tick();
        MemWrite   = 1'b0;
        Address    = BASE;
    endtask

    task automatic peek(input string tag, input logic [31:0] a,
                        input logic [31:0] exp);
        Address = a;
        #1;
        chk(tag, Read_data, exp);
        Address = BASE;
    endtask

    initial begin
        Address = BASE; Write_data = 0; MemWrite = 0; MemRead = 1;
        irq_src = 0; cpu_ack = 0; reset = 1;
        do_reset();
        chk("rst_ipend", Read_data, 32'h0);
        tick(); tick();

        // single timer interrupt through the full handshake
        store(BASE + 4, 32'hFFFF_FFF1);
        peek("imask_upper", BASE + 4, 32'h1);
        irq_src = 4'b0001;
        tick();
        chk("t_pend", Read_data, 32'h1);
        chk("t_out0", {31'h0, irq_out}, 32'h0);
        tick();
        chk("t_out1", {31'h0, irq_out}, 32'h1);
        chk("t_id", {30'h0, irq_id}, 32'h0);
        cpu_ack = 1; tick(); cpu_ack = 0;
        chk("t_svc_pend", Read_data, 32'h0);
        chk("t_svc_out", {31'h0, irq_out}, 32'h0);
        store(BASE + 12, 32'h0);
        chk("t_eoi_out", {31'h0, irq_out}, 32'h0);
        tick();
        chk("t_eoi_out2", {31'h0, irq_out}, 32'h0);
        peek("eoi_reads0", BASE + 12, 32'h0);
        irq_src = 0; tick();

        // two simultaneous sources, priority and EOI re-request
        store(BASE + 4, 32'hF);
        irq_src = 4'b1010;
        tick();
        chk("p_pend", Read_data, 32'hA);
        tick();
        chk("p_out", {31'h0, irq_out}, 32'h1);
        chk("p_id1", {30'h0, irq_id}, 32'h1);
        cpu_ack = 1; tick(); cpu_ack = 0;
        chk("p_ack_pend", Read_data, 32'h8);
        cpu_ack = 1; tick(); cpu_ack = 0;
        chk("p_svc_ack_ign", Read_data, 32'h8);
        store(BASE + 12, 32'h0);
        chk("p_eoi_idle", {31'h0, irq_out}, 32'h0);
        tick();
        chk("p_rereq", {31'h0, irq_out}, 32'h1);
        chk("p_id3", {30'h0, irq_id}, 32'h3);
        peek("p_icause", BASE + 8, 32'h3);
        cpu_ack = 1; tick(); cpu_ack = 0;
        store(BASE + 12, 32'h0);
        irq_src = 0; tick();

        // masked pending becomes requested once unmasked
        store(BASE + 4, 32'h0);
        irq_src = 4'b0100;
        tick();
        chk("m_pend", Read_data, 32'h4);
        tick();
        chk("m_out0", {31'h0, irq_out}, 32'h0);
        store(BASE + 4, 32'h4);
        chk("m_out_w", {31'h0, irq_out}, 32'h0);
        tick();
        chk("m_out1", {31'h0, irq_out}, 32'h1);
        chk("m_id2", {30'h0, irq_id}, 32'h2);

        // W1C withdraws a request before ack
        store(BASE, 32'h4);
        tick();
        chk("w_out0", {31'h0, irq_out}, 32'h0);
        irq_src = 0; tick();
        store(BASE + 4, 32'h1);
        irq_src = 4'b0001;
        tick(); tick();
        chk("w_id0", {30'h0, irq_id}, 32'h0);
        chk("w_req", {31'h0, irq_out}, 32'h1);
        store(BASE, 32'h1);
        tick();
        chk("w0_out0", {31'h0, irq_out}, 32'h0);
        chk("w0_pend", Read_data, 32'h0);

        // set beats same-cycle clear, then reset during service
        irq_src = 0; tick();
        irq_src = 4'b0001;
        store(BASE, 32'h1);
        chk("set_wins", Read_data, 32'h1);
        tick();
        cpu_ack = 1; tick(); cpu_ack = 0;
        chk("svc_out", {31'h0, irq_out}, 32'h0);
        do_reset();
        chk("rr_pend", Read_data, 32'h0);
        peek("rr_mask", BASE + 4, 32'h0);
        store(BASE + 4, 32'h1);
        tick(); tick();
        chk("held_no_edge", Read_data, 32'h0);
        chk("held_no_out", {31'h0, irq_out}, 32'h0);

        // random traffic against the model
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(99) == 0) begin
                do_reset();
            end
            if ($urandom_range(3) == 0) irq_src[$urandom_range(3)] ^= 1'b1;
            cpu_ack  = ($urandom_range(3) == 0);
            MemRead  = ($urandom_range(3) != 0);
            MemWrite = ($urandom_range(3) == 0);
            case ($urandom_range(5))
                0: Address = BASE;
                1: Address = BASE + 32'd4;
                2: Address = BASE + 32'd8;
                3: Address = BASE + 32'd12;
                4: Address = BASE + 32'd16;
                default: Address = BASE - 32'd4;
            endcase
            Write_data = $urandom;
            tick();
        end
        MemWrite = 0;
        cpu_ack  = 0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
